ibex_vector_window_gen: RTL



---
 rtl/ibex_vector_pkg.sv | 56 +++++
 rtl/ibex_vector_line_buf.sv | 33 +++
 rtl/ibex_vector_window_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ibex_vector_pkg.sv
// ibex_vector_pkg
//   Shared types and constants for the 3x3 window generator that feeds the
//   9-lane vector MAC filter.
//   - win_lane_e      : byte-lane index of each tap inside a packed window
//   - win_gen_state_e : window generator FSM states
//   - win_col_t       : one vertical 3-pixel column (row-2, row-1, current)
//   - pack_window()   : assembles three columns into the 72-bit lane order
package ibex_vector_pkg;

   localparam int unsigned WIN_LANES = 9;
   localparam int unsigned PIX_W     = 8;

   typedef enum logic [3:0] {
      WIN_C  = 4'd0,
      WIN_N  = 4'd1,
      WIN_S  = 4'd2,
      WIN_W  = 4'd3,
      WIN_E  = 4'd4,
      WIN_NW = 4'd5,
      WIN_NE = 4'd6,
      WIN_SW = 4'd7,
      WIN_SE = 4'd8
   } win_lane_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } win_gen_state_e;

   typedef struct packed {
      logic [PIX_W-1:0] top;   // row-2
      logic [PIX_W-1:0] mid;   // row-1
      logic [PIX_W-1:0] bot;   // current row
   } win_col_t;

   // left = column x-2, mid = column x-1, right = column x (newest)
   function automatic logic [WIN_LANES*PIX_W-1:0] pack_window(
      input win_col_t left,
      input win_col_t mid,
      input win_col_t right
   );
      logic [WIN_LANES*PIX_W-1:0] w;
      w = '0;
      w[int'(WIN_C )*PIX_W +: PIX_W] = mid.mid;
      w[int'(WIN_N )*PIX_W +: PIX_W] = mid.top;
      w[int'(WIN_S )*PIX_W +: PIX_W] = mid.bot;
      w[int'(WIN_W )*PIX_W +: PIX_W] = left.mid;
      w[int'(WIN_E )*PIX_W +: PIX_W] = right.mid;
      w[int'(WIN_NW)*PIX_W +: PIX_W] = left.top;
      w[int'(WIN_NE)*PIX_W +: PIX_W] = right.top;
      w[int'(WIN_SW)*PIX_W +: PIX_W] = left.bot;
      w[int'(WIN_SE)*PIX_W +: PIX_W] = right.bot;
      return w;
   endfunction

endpackage

// File: rtl/ibex_vector_line_buf.sv
// ibex_vector_line_buf
//   One image line of pixel storage. Combinational read, synchronous write;
//   a read and a write to the same address in one cycle returns the old value.
//   Ports:
//     clk_i       clock
//     i_we        write enable
//     i_addr      read/write address (pixel column)
//     i_wr_data   data written at i_addr on the rising edge when i_we
//     o_rd_data   current contents at i_addr
module ibex_vector_line_buf
   import ibex_vector_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [PIX_W-1:0] i_wr_data,
   output logic [PIX_W-1:0] o_rd_data
);

   logic [PIX_W-1:0] r_mem [DEPTH];

   assign o_rd_data = r_mem[i_addr];

   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wr_data;
      end
   end

endmodule

// File: rtl/ibex_vector_window_gen.sv
// ibex_vector_window_gen
//   Turns a raster pixel stream into packed 3x3 neighbourhoods, one per
//   interior pixel, for the vector MAC filter.
//   Ports:
//     clk_i, rst_i    clock, synchronous active-high reset
//     pix_valid_i     input pixel valid
//     pix_ready_o     input pixel accepted when valid && ready
//     pix_data_i      8-bit pixel
//     pix_sof_i       first pixel of a frame
//     win_valid_o     window valid
//     win_ready_i     downstream takes the window
//     win_data_o      window in [71:0], upper bits zero
//     win_last_o      final window of the frame
//     frame_done_o    pulse after the last pixel of a frame is accepted
module ibex_vector_window_gen
   import ibex_vector_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 pix_valid_i,
   output logic                 pix_ready_o,
   input  logic [PIX_W-1:0]     pix_data_i,
   input  logic                 pix_sof_i,
   output logic                 win_valid_o,
   input  logic                 win_ready_i,
   output logic [127:0]         win_data_o,
   output logic                 win_last_o,
   output logic                 frame_done_o
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
   localparam int unsigned WIN_W_BITS = WIN_LANES * PIX_W;

   win_gen_state_e r_state, w_state_n;
   logic [RW-1:0]  r_row, w_row_n, w_row;
   logic [CW-1:0]  r_col, w_col_n, w_col;

   logic w_accept, w_active, w_at_end, w_win_fire;
   logic [PIX_W-1:0] w_lb1_rd, w_lb2_rd;
   win_col_t w_new_col, r_col1, r_col2;

   logic                  r_win_valid;
   logic [WIN_W_BITS-1:0] r_win_data;
   logic                  r_win_last;
   logic                  r_frame_done;

   assign pix_ready_o = !r_win_valid || win_ready_i;
   assign w_accept    = pix_valid_i && pix_ready_o;
   // An accepted sof starts a frame from any state; otherwise only S_RUN
   // pixels take part, and S_IDLE pixels are dropped.
   assign w_active    = w_accept && (pix_sof_i || (r_state == S_RUN));
   assign w_row       = pix_sof_i ? '0 : r_row;
   assign w_col       = pix_sof_i ? '0 : r_col;
   assign w_at_end    = (w_row == ROW_MAX) && (w_col == COL_MAX);
   assign w_win_fire  = w_active && (w_row >= RW'(2)) && (w_col >= CW'(2));

   always_comb begin
      w_state_n = r_state;
      w_row_n   = r_row;
      w_col_n   = r_col;
      if (w_active) begin
         if (w_at_end) begin
            w_state_n = S_IDLE;
            w_row_n   = '0;
            w_col_n   = '0;
         end else begin
            w_state_n = S_RUN;
            if (w_col == COL_MAX) begin
               w_col_n = '0;
               w_row_n = w_row + 1'b1;
            end else begin
               w_col_n = w_col + 1'b1;
               w_row_n = w_row;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_state_n;
         r_row   <= w_row_n;
         r_col   <= w_col_n;
      end
   end

   // lb1 = previous line, lb2 = line before; lb2 takes lb1's old value.
   ibex_vector_line_buf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
      .clk_i     (clk_i),
      .i_we      (w_active),
      .i_addr    (w_col),
      .i_wr_data (pix_data_i),
      .o_rd_data (w_lb1_rd)
   );

   ibex_vector_line_buf #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb2 (
      .clk_i     (clk_i),
      .i_we      (w_active),
      .i_addr    (w_col),
      .i_wr_data (w_lb1_rd),
      .o_rd_data (w_lb2_rd)
   );

   assign w_new_col = '{top: w_lb2_rd, mid: w_lb1_rd, bot: pix_data_i};

   // Only the two older columns are stored; the newest is the live input.
   // Stale columns across a line wrap are masked by the col >= 2 gate.
   always_ff @(posedge clk_i) begin
      if (w_active) begin
         r_col1 <= w_new_col;
         r_col2 <= r_col1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_win_valid  <= 1'b0;
         r_win_data   <= '0;
         r_win_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_active && w_at_end;
         if (w_win_fire) begin
            r_win_valid <= 1'b1;
            r_win_data  <= pack_window(r_col2, r_col1, w_new_col);
            r_win_last  <= w_at_end;
         end else if (win_ready_i) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign win_valid_o              = r_win_valid;
   assign win_data_o[127:WIN_W_BITS] = '0;
   assign win_data_o[WIN_W_BITS-1:0] = r_win_data;
   assign win_last_o               = r_win_last;
   assign frame_done_o             = r_frame_done;

endmodule
